logic_shift_sequencer: RTL and testbench
========================================

// Module: logic_shift_sequencer
// PURPOSE
//  Multi-cycle controller that sequences the 32-bit Logic unit (AND/OR/XOR, 1-bit logical/arithmetic shifts).
//  The Logic unit shifts by one position per pass; this block iterates it to realise shift-by-N (N = B[4:0]).
//  It latches one operation on a start/done handshake and feeds the Logic unit from an internal accumulator.
//  It sits between ALU control and the Logic unit.
// PARAMETERS
//  WIDTH    32  datapath width; must match the Logic unit
//  SHAMT_W  5   shift-amount bits taken from B[SHAMT_W-1:0]
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      synchronous, active-high reset
//  start         in   1      request; sampled only when busy=0
//  opcode        in   3      000 AND, 001 OR, 010 XOR, 011 LSL, 100 LSR, 101 ASL, 110 ASR, 111 zero
//  a             in   WIDTH  operand A (value to shift for shift ops)
//  b             in   WIDTH  operand B (bitwise ops) / shift amount in B[SHAMT_W-1:0]
//  busy          out  1      high while in EXEC
//  done          out  1      one-cycle pulse; result valid in that cycle
//  result        out  WIDTH  final answer; held until next accepted start
//  logic_a       out  WIDTH  to Logic unit A = accumulator register
//  logic_b       out  WIDTH  to Logic unit B = latched b
//  logic_opcode  out  3      to Logic unit OpCode = latched opcode
//  logic_answer  in   WIDTH  from Logic unit LogicAnswer (combinational)
// BEHAVIOUR
//  - One clock, synchronous active-high reset. Reset values: state=IDLE, acc=0, b_reg=0, op_reg=000,
//    cnt=0, busy=0, done=0, result=0 (result = acc).
//  - States: IDLE, EXEC, DONE. busy = (state==EXEC); done = (state==DONE).
//  - Accept: start=1 and state in {IDLE, DONE} at an edge: acc<=a, b_reg<=b, op_reg<=opcode, cnt<=N.
//    N = 1 for opcodes 000/001/010/111; N = b[SHAMT_W-1:0] for 011-110; b[WIDTH-1:SHAMT_W] ignored.
//  - Next state on accept: N=0 -> DONE (result = a unchanged); else EXEC.
//  - EXEC, each edge: acc<=logic_answer, cnt<=cnt-1; when cnt==1 -> DONE, else stay EXEC.
//  - DONE: single cycle; -> EXEC/DONE if new start accepted, else -> IDLE. Back-to-back starts allowed.
//  - Latency: start sampled at edge k -> done high in cycle k+1+N (bitwise ops: 2 cycles; shift by 0: 1).
//  - start while busy=1: ignored, no effect on state, operands or counter.
//  - Input changes on a/b/opcode after acceptance have no effect (all operands latched).
//  - result/acc stays stable in IDLE; changes only on accept or EXEC edges.
//  - logic_opcode/logic_b constant for the whole operation; logic_a steps through intermediate values.
//  - Reset mid-EXEC: aborts, returns to IDLE with reset values, no done pulse.
//  - Reset and start same edge: reset wins, request dropped.
//  - ASL shifts are 1-bit left (identical to LSL in Logic unit); ASR replicates bit WIDTH-1 each pass.
//  - Opcode 111: one pass, result 0.
// TESTING
//  1 AND a=F0F0F0F0 b=FF00FF00 -> done 2 cycles after start, result=F000F000, busy high 1 cycle.
//  2 ASR a=80000000 b=00000004 -> busy 4 cycles, logic_opcode=110 throughout, result=F8000000.
//  3 LSL a=12345678 b=00000020 (N=0) -> done next cycle, result=12345678, busy never high.
//  4 LSR a=80000000 b=0000001F -> done 32 cycles after start, result=00000001; b=00000025 -> shift 5.
//  5 start pulsed with XOR operands during a 10-step LSL -> ignored; LSL result correct, one done pulse.
//  6 reset asserted mid-shift -> next cycle busy=0, done=0, result=0; start with start+reset same edge ignored.

Source files
------------

// File: rtl/logic_shift_sequencer.sv
// logic_shift_sequencer: iterates a one-position-per-pass Logic unit to realise bitwise ops and shift-by-N
module logic_shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] logic_a,
  output logic [WIDTH-1:0] logic_b,
  output logic [2:0]       logic_opcode,
  input  logic [WIDTH-1:0] logic_answer
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, nextState;
  logic [WIDTH-1:0] acc, bReg;
  logic [2:0] opReg;
  logic [SHAMT_W-1:0] cnt, reqCnt;
  logic accept, isShift;
  // Bitwise ops and opcode 111 take exactly one pass; shifts take B[SHAMT_W-1:0] passes
  always_comb begin
    isShift = opcode >= 3'b011 && opcode <= 3'b110;
    reqCnt = isShift ? b[SHAMT_W-1:0] : SHAMT_W'(1);
    accept = start && state != EXEC;
    nextState = accept ? (reqCnt == '0 ? DONE : EXEC)
              : state == EXEC ? (cnt == SHAMT_W'(1) ? DONE : EXEC) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      bReg <= '0;
      opReg <= '0;
      cnt <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        acc <= a;
        bReg <= b;
        opReg <= opcode;
        cnt <= reqCnt;
      end else if (state == EXEC) begin
        acc <= logic_answer;
        cnt <= cnt - SHAMT_W'(1);
      end
    end
  end
  assign busy = state == EXEC;
  assign done = state == DONE;
  assign result = acc;
  assign logic_a = acc;
  assign logic_b = bReg;
  assign logic_opcode = opReg;
endmodule

// File: tb/tb_logic_shift_sequencer.sv
// tb_logic_shift_sequencer: directed vectors with a queue scoreboard checked on each done pulse
module tb_logic_shift_sequencer;
  logic clk = 0, reset, start;
  logic [2:0] opcode, logic_opcode;
  logic [31:0] a, b, result, logic_a, logic_b, logic_answer;
  logic busy, done;
  int checks = 0, errors = 0, cyc = 0, busyCnt = 0;
  typedef struct {logic [31:0] res; int due; int lat; logic [2:0] op; logic [31:0] b;} exp_t;
  exp_t q[$];
  exp_t e;

  logic_shift_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .logic_a(logic_a), .logic_b(logic_b),
    .logic_opcode(logic_opcode), .logic_answer(logic_answer)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference Logic unit: one pass of the selected operation
  always_comb begin
    logic_answer = '0;
    case (logic_opcode)
      3'b000: logic_answer = logic_a & logic_b;
      3'b001: logic_answer = logic_a | logic_b;
      3'b010: logic_answer = logic_a ^ logic_b;
      3'b011, 3'b101: logic_answer = logic_a << 1;
      3'b100: logic_answer = logic_a >> 1;
      3'b110: logic_answer = {logic_a[31], logic_a[31:1]};
      default: logic_answer = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] res, input int n);
    opcode = op; a = av; b = bv; start = 1;
    q.push_back('{res, cyc + 1 + n, n, op, bv});
    @(negedge clk);
    start = 0; a = $urandom; b = $urandom; opcode = 3'($urandom);
  endtask

  always @(negedge clk) begin
    if (!busy && !done) busyCnt = 0;
    if (busy) busyCnt++;
    if (busy && q.size() > 0) begin
      chk("logic_opcode", {29'd0, logic_opcode}, {29'd0, q[0].op});
      chk("logic_b", logic_b, q[0].b);
    end
    if (done) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: result %h with no request outstanding", result);
      end else begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("done_cycle", cyc, e.due);
        chk("busy_cycles", busyCnt, e.lat);
      end
      busyCnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; start = 0; opcode = 0; a = 0; b = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_result", result, 0);
    chk("rst_logic_b", logic_b, 0);
    chk("rst_logic_op", {29'd0, logic_opcode}, 0);
    reset = 0;
    @(negedge clk);
    issue(3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1); repeat (3) @(negedge clk);
    issue(3'b110, 32'h80000000, 32'h00000004, 32'hF8000000, 4); repeat (6) @(negedge clk);
    issue(3'b011, 32'h12345678, 32'h00000020, 32'h12345678, 0); repeat (2) @(negedge clk);
    issue(3'b100, 32'h80000000, 32'h0000001F, 32'h00000001, 31); repeat (33) @(negedge clk);
    issue(3'b100, 32'h80000000, 32'h00000025, 32'h04000000, 5); repeat (7) @(negedge clk);
    // back-to-back requests accepted from DONE
    issue(3'b001, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1); @(negedge clk);
    issue(3'b010, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1); @(negedge clk);
    issue(3'b111, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 1); @(negedge clk);
    issue(3'b101, 32'h00000003, 32'hFFFFFFE2, 32'h0000000C, 2); repeat (4) @(negedge clk);
    issue(3'b110, 32'h7FFFFFFF, 32'h00000003, 32'h0FFFFFFF, 3); repeat (5) @(negedge clk);
    // start while busy is ignored
    issue(3'b011, 32'h00000001, 32'h0000000A, 32'h00000400, 10); repeat (3) @(negedge clk);
    opcode = 3'b010; a = 32'hFFFFFFFF; b = 32'h0000FFFF; start = 1;
    @(negedge clk);
    start = 0; repeat (10) @(negedge clk);
    chk("idle_hold", result, 32'h00000400);
    chk("idle_busy", {31'd0, busy}, 0);
    // reset mid-shift aborts, then reset with start drops the request
    issue(3'b100, 32'h80000000, 32'h00000014, 32'h00000800, 20); repeat (5) @(negedge clk);
    reset = 1; q.delete();
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_result", result, 0);
    opcode = 3'b000; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1;
    @(negedge clk);
    reset = 0; start = 0;
    chk("rst_start_result", result, 0);
    chk("rst_start_busy", {31'd0, busy}, 0);
    repeat (2) @(negedge clk);
    chk("rst_start_done", {31'd0, done}, 0);
    chk("rst_start_idle", result, 0);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL missing_done: %0d requests never completed", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
